// File: rtl/decode_seq_ctrl_if.sv
// Handshake bundle between the decode stage and the multi-cycle sequencer.
// The master drives requests and pipeline advance; the slave (sequencer)
// returns stall/stack/flush controls.
interface decode_seq_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             en;
  logic             call_i;
  logic             ret_i;
  logic             rti_i;
  logic             int_i;
  logic             busy_o;
  logic             stall_o;
  logic             push_o;
  logic             pop_o;
  logic [IDX_W-1:0] word_idx_o;
  logic             flags_sel_o;
  logic             second_o;
  logic             flush_o;
  logic             int_ack_o;
  logic [1:0]       op_o;

  modport master (
    output en, call_i, ret_i, rti_i, int_i,
    input  busy_o, stall_o, push_o, pop_o, word_idx_o,
           flags_sel_o, second_o, flush_o, int_ack_o, op_o
  );

  modport slave (
    input  en, call_i, ret_i, rti_i, int_i,
    output busy_o, stall_o, push_o, pop_o, word_idx_o,
           flags_sel_o, second_o, flush_o, int_ack_o, op_o
  );
endinterface

// File: rtl/decode_seq_ctrl.sv
// Decode-stage sequencer: expands CALL/INT into N-word stack pushes and
// RET/RTI into N-word pops, then issues a one-cycle flush. INT/RTI carry an
// optional extra flags word. Interrupt edges are latched as pending and are
// taken with top priority from IDLE.
module decode_seq_ctrl #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 32,
  parameter int SAVE_FLAGS = 1,
  parameter int IDX_W      = $clog2((PC_W / DATA_W) + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  decode_seq_ctrl_if.slave         bus
);

  localparam int WORDS = PC_W / DATA_W;
  localparam logic [IDX_W-1:0] LAST_CR = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IR = IDX_W'(WORDS + SAVE_FLAGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_FLUSH} state_t;
  typedef enum logic [1:0] {OP_CALL = 2'b00, OP_INT = 2'b01,
                            OP_RET  = 2'b10, OP_RTI = 2'b11} op_t;

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_int_pend, r_int_prev;
  logic             w_int_edge, w_accept_int, w_is_ir, w_last;
  logic [IDX_W-1:0] w_last_idx;

  logic             w_busy, w_stall, w_push, w_pop, w_fsel, w_second;
  logic             w_flush, w_ack;
  logic [IDX_W-1:0] w_idx;

  assign w_int_edge = bus.int_i & ~r_int_prev;
  assign w_is_ir    = (r_op == OP_INT) || (r_op == OP_RTI);
  assign w_last_idx = w_is_ir ? LAST_IR : LAST_CR;
  assign w_last     = (r_cnt == w_last_idx);

  // State, counter, op and interrupt-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_CALL;
      r_int_pend <= 1'b0;
      r_int_prev <= 1'b0;
    end else begin
      // Edge capture runs even while the pipeline is frozen; a fresh edge
      // outranks the clear from the interrupt being accepted this cycle.
      r_int_prev <= bus.int_i;
      r_int_pend <= w_int_edge | (r_int_pend & ~w_accept_int);
      if (bus.en) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_op    <= w_op_nxt;
      end
    end
  end

  // Next-state selection and Moore decode of the sequencer outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_accept_int = 1'b0;
    w_busy       = (r_state != S_IDLE);
    w_stall      = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_idx        = '0;
    w_fsel       = 1'b0;
    w_second     = 1'b0;
    w_flush      = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Any request holds decode so a deferred instruction is not lost.
        w_stall = r_int_pend | w_int_edge | bus.call_i | bus.ret_i | bus.rti_i;
        if (bus.en) begin
          if (r_int_pend) begin
            w_op_nxt     = OP_INT;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_PUSH;
            w_accept_int = 1'b1;
          end else if (w_int_edge) begin
            // Interrupt arriving now will be pending next cycle; do not
            // let a lower-priority request start ahead of it.
            w_state_nxt = S_IDLE;
          end else if (bus.call_i) begin
            w_op_nxt    = OP_CALL;
            w_cnt_nxt   = '0;
            w_state_nxt = S_PUSH;
          end else if (bus.ret_i) begin
            w_op_nxt    = OP_RET;
            w_cnt_nxt   = '0;
            w_state_nxt = S_POP;
          end else if (bus.rti_i) begin
            w_op_nxt    = OP_RTI;
            w_cnt_nxt   = '0;
            w_state_nxt = S_POP;
          end
        end
      end
      S_PUSH, S_POP: begin
        w_stall  = 1'b1;
        w_push   = (r_state == S_PUSH);
        w_pop    = (r_state == S_POP);
        w_idx    = r_cnt;
        w_second = (r_cnt != '0);
        // Flags word is the last push of INT and the first pop of RTI.
        if (SAVE_FLAGS != 0) begin
          w_fsel = ((r_state == S_PUSH) && (r_op == OP_INT) && w_last) ||
                   ((r_state == S_POP)  && (r_op == OP_RTI) && (r_cnt == '0));
        end
        if (bus.en) begin
          if (w_last) w_state_nxt = S_FLUSH;
          else        w_cnt_nxt   = r_cnt + IDX_W'(1);
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        w_ack   = (r_op == OP_INT);
        if (bus.en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy_o      = w_busy;
  assign bus.stall_o     = w_stall;
  assign bus.push_o      = w_push;
  assign bus.pop_o       = w_pop;
  assign bus.word_idx_o  = w_idx;
  assign bus.flags_sel_o = w_fsel;
  assign bus.second_o    = w_second;
  assign bus.flush_o     = w_flush;
  assign bus.int_ack_o   = w_ack;
  assign bus.op_o        = r_op;

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// Bench for decode_seq_ctrl with WORDS=2, SAVE_FLAGS=1 (CALL/RET 2 words,
// INT/RTI 3 words). Cycle vectors carry inputs and expected outputs; the
// expectation is queued when the inputs are driven and compared when the
// outputs are sampled on the falling edge.
module tb_decode_seq_ctrl;
  localparam int DATA_W     = 16;
  localparam int PC_W       = 32;
  localparam int SAVE_FLAGS = 1;
  localparam int IDX_W      = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

  decode_seq_ctrl #(
    .DATA_W(DATA_W), .PC_W(PC_W), .SAVE_FLAGS(SAVE_FLAGS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // exp/got layout: {busy,stall,push,pop,idx[1:0],fsel,second,flush,ack,op[1:0]}
  typedef struct {
    int         sec;
    logic       r, e, c, rt, ri, it;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic add(input int s, input int r, e, c, rt, ri, it,
                     input int b, st, pu, po, ix, f, sc, fl, a, o);
    vec_t v;
    v.sec = s;
    v.r = 1'(r); v.e = 1'(e); v.c = 1'(c); v.rt = 1'(rt); v.ri = 1'(ri); v.it = 1'(it);
    v.exp = {1'(b), 1'(st), 1'(pu), 1'(po), 2'(ix), 1'(f), 1'(sc), 1'(fl), 1'(a), 2'(o)};
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] got_now();
    return {bus.busy_o, bus.stall_o, bus.push_o, bus.pop_o, bus.word_idx_o,
            bus.flags_sel_o, bus.second_o, bus.flush_o, bus.int_ack_o, bus.op_o};
  endfunction

  task automatic drive(input logic r, e, c, rt, ri, it);
    @(posedge clk);
    #1;
    rst = r; bus.en = e; bus.call_i = c; bus.ret_i = rt; bus.rti_i = ri; bus.int_i = it;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, req);
  endtask

  initial begin
    int pushes, flushes, flush_cyc, acks, cyc;
    logic [11:0] e, g;
    logic done;
    bit en_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    //   sec r e c rt ri it   busy st pu po ix f sc fl a op
    add(0, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // CALL
    add(1, 0,1,1,0,0,0,  0,1,0,0,0,0,0,0,0,0);
    add(1, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,0);
    add(1, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(1, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,0);
    add(1, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // INT pulse
    add(2, 0,1,0,0,0,1,  0,1,0,0,0,0,0,0,0,0);
    add(2, 0,1,0,0,0,0,  0,1,0,0,0,0,0,0,0,0);
    add(2, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,1);
    add(2, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(2, 0,1,0,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(2, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(2, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);
    // RTI
    add(3, 0,1,0,0,1,0,  0,1,0,0,0,0,0,0,0,1);
    add(3, 0,1,0,0,0,0,  1,1,0,1,0,1,0,0,0,3);
    add(3, 0,1,0,0,0,0,  1,1,0,1,1,0,1,0,0,3);
    add(3, 0,1,0,0,0,0,  1,1,0,1,2,0,1,0,0,3);
    add(3, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,3);
    add(3, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,3);
    // INT and CALL together: INT first, held CALL afterwards
    add(4, 0,1,1,0,0,1,  0,1,0,0,0,0,0,0,0,3);
    add(4, 0,1,1,0,0,0,  0,1,0,0,0,0,0,0,0,3);
    add(4, 0,1,1,0,0,0,  1,1,1,0,0,0,0,0,0,1);
    add(4, 0,1,1,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(4, 0,1,1,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(4, 0,1,1,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(4, 0,1,1,0,0,0,  0,1,0,0,0,0,0,0,0,1);
    add(4, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,0);
    add(4, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(4, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,0);
    add(4, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // CALL frozen at idx1 for three cycles
    add(5, 0,1,1,0,0,0,  0,1,0,0,0,0,0,0,0,0);
    add(5, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,0);
    add(5, 0,0,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(5, 0,0,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(5, 0,0,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(5, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,0);
    add(5, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,0);
    add(5, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // RET beats RTI
    add(6, 0,1,0,1,1,0,  0,1,0,0,0,0,0,0,0,0);
    add(6, 0,1,0,0,0,0,  1,1,0,1,0,0,0,0,0,2);
    add(6, 0,1,0,0,0,0,  1,1,0,1,1,0,1,0,0,2);
    add(6, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,2);
    add(6, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,2);
    // Reset during POP idx0
    add(7, 0,1,0,1,0,0,  0,1,0,0,0,0,0,0,0,2);
    add(7, 1,1,0,0,0,0,  1,1,0,1,0,0,0,0,0,2);
    add(7, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    add(7, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // Interrupt edge during RET stays pending, taken after FLUSH
    add(8, 0,1,0,1,0,0,  0,1,0,0,0,0,0,0,0,0);
    add(8, 0,1,0,0,0,1,  1,1,0,1,0,0,0,0,0,2);
    add(8, 0,1,0,0,0,0,  1,1,0,1,1,0,1,0,0,2);
    add(8, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,2);
    add(8, 0,1,0,0,0,0,  0,1,0,0,0,0,0,0,0,2);
    add(8, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,1);
    add(8, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(8, 0,1,0,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(8, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(8, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);
    // Long int_i level gives only one INT
    add(9, 0,1,0,0,0,1,  0,1,0,0,0,0,0,0,0,1);
    add(9, 0,1,0,0,0,1,  0,1,0,0,0,0,0,0,0,1);
    add(9, 0,1,0,0,0,1,  1,1,1,0,0,0,0,0,0,1);
    add(9, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(9, 0,1,0,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(9, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(9, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);
    add(9, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);
    // New edge in the accepting cycle keeps the interrupt pending
    add(10, 0,1,0,1,0,0,  0,1,0,0,0,0,0,0,0,1);
    add(10, 0,1,0,0,0,1,  1,1,0,1,0,0,0,0,0,2);
    add(10, 0,1,0,0,0,0,  1,1,0,1,1,0,1,0,0,2);
    add(10, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,0,2);
    add(10, 0,1,0,0,0,1,  0,1,0,0,0,0,0,0,0,2);
    add(10, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,1);
    add(10, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(10, 0,1,0,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(10, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(10, 0,1,0,0,0,0,  0,1,0,0,0,0,0,0,0,1);
    add(10, 0,1,0,0,0,0,  1,1,1,0,0,0,0,0,0,1);
    add(10, 0,1,0,0,0,0,  1,1,1,0,1,0,1,0,0,1);
    add(10, 0,1,0,0,0,0,  1,1,1,0,2,1,1,0,0,1);
    add(10, 0,1,0,0,0,0,  1,0,0,0,0,0,0,1,1,1);
    add(10, 0,1,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);

    rst = 1'b1; bus.en = 1'b0; bus.call_i = 1'b0; bus.ret_i = 1'b0;
    bus.rti_i = 1'b0; bus.int_i = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].rt, vecs[i].ri, vecs[i].it);
      sb_q.push_back(vecs[i].exp);
      @(negedge clk);
      g = got_now();
      e = sb_q.pop_front();
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL vec%0d sec%0d got=%b expected=%b (busy,stall,push,pop,idx,fsel,second,flush,ack,op)",
                    i, vecs[i].sec, g, e);
    end

    // CALL with en=0 both mid-push and inside FLUSH: flush held, counts exact.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pushes = 0; flushes = 0; flush_cyc = 0; acks = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 30) begin
      drive(1'b0, (cyc < 8) ? en_pat[cyc] : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.push_o && bus.en) pushes++;
      if (bus.flush_o && bus.en) flushes++;
      if (bus.flush_o) flush_cyc++;
      if (bus.int_ack_o) acks++;
      if (!bus.busy_o) done = 1'b1;
      cyc++;
    end
    check_int("hold_done", int'(done), 1);
    check_int("hold_pushes", pushes, 2);
    check_int("hold_flushes", flushes, 1);
    check_int("hold_flush_cycles", flush_cyc, 3);
    check_int("hold_no_ack", acks, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
